// File: rtl/lifo_pkg.sv
// Shared definitions for the LIFO stack: operation encoding and sizing helpers.
// Used by both the control logic and its testbench.
package lifo_pkg;

    typedef enum logic [2:0] {
        OP_IDLE,
        OP_PUSH,
        OP_POP,
        OP_REPLACE,
        OP_CLEAR
    } op_e;

    // Bits needed to hold an occupancy in the range 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Collapse the raw request lines into one operation; clear dominates.
    function automatic op_e decode_op(input logic clear, input logic push, input logic pop);
        if (clear)
            return OP_CLEAR;
        if (push && pop)
            return OP_REPLACE;
        if (push)
            return OP_PUSH;
        if (pop)
            return OP_POP;
        return OP_IDLE;
    endfunction

endpackage

// File: rtl/lifo_stack_mem.sv
// DEPTH x WIDTH register array for the LIFO stack.
// One synchronous write port and one asynchronous read port.
module lifo_stack_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: storage has no reset; occupancy alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/lifo_stack_ctrl.sv
// Parametrised LIFO stack controller: occupancy, flags, registered pop data,
// replace-top on simultaneous push/pop, synchronous clear and error pulses.
module lifo_stack_ctrl
    import lifo_pkg::*;
#(
    parameter  int WIDTH     = 8,
    parameter  int DEPTH     = 8,
    parameter  int AF_THRESH = 6,
    localparam int CW        = count_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic [WIDTH-1:0] top,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             almost_full,
    output logic             overflow,
    output logic             underflow
);

    localparam int AW = $clog2(DEPTH);

    op_e             op;
    logic [CW-1:0]   top_idx;
    logic            we;
    logic [AW-1:0]   waddr;
    logic [AW-1:0]   raddr;
    logic [WIDTH-1:0] rdata;

    assign op          = decode_op(clear, push, pop);
    assign empty       = (count == '0);
    assign full        = (count == CW'(DEPTH));
    assign almost_full = (count >= CW'(AF_THRESH));
    assign top_idx     = count - CW'(1);
    assign raddr       = empty ? '0 : AW'(top_idx);
    assign top         = empty ? '0 : rdata;

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        we    = 1'b0;
        waddr = AW'(count);
        unique case (op)
            OP_PUSH:    we = !full;
            OP_REPLACE: begin
                we = 1'b1;
                // An empty replace degrades to a plain push into slot 0.
                if (!empty)
                    waddr = AW'(top_idx);
            end
            default:    we = 1'b0;
        endcase
    end

    lifo_stack_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (din),
        .raddr (raddr),
        .rdata (rdata)
    );

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count      <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            dout_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
            unique case (op)
                OP_CLEAR: count <= '0;
                OP_REPLACE: begin
                    if (!empty) begin
                        dout       <= rdata;
                        dout_valid <= 1'b1;
                    end else begin
                        count     <= CW'(1);
                        underflow <= 1'b1;
                    end
                end
                OP_PUSH: begin
                    if (!full)
                        count <= count + CW'(1);
                    else
                        overflow <= 1'b1;
                end
                OP_POP: begin
                    if (!empty) begin
                        dout       <= rdata;
                        dout_valid <= 1'b1;
                        count      <= top_idx;
                    end else begin
                        underflow <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
